// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared FSM state type and byte width for the byte-serial add/sub controller
package add_seq_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/add8_slice.sv
// add8_slice: combinational 8-bit adder slice (a, b, cin -> sum, cout), no operand inversion
module add8_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: byte-serial WIDTH-bit add/sub with valid/ready handshake (in_valid/in_ready/a/b/sub in, out_valid/out_ready/result/flag_n/z/c/v out); flags built only when ADD_SEQ_FLAGS_EN is defined
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);
    localparam int N  = WIDTH / BYTE_W;
    localparam int KW = $clog2(N);
    state_t          state;
    logic [WIDTH-1:0] a_r, b_r, res_next;
    logic            carry, cout, last;
    logic [KW-1:0]   k;
    logic [7:0]      sum;
    add8_slice u_slice (.a(a_r[7:0]), .b(b_r[7:0]), .cin(carry), .sum(sum), .cout(cout));
    assign in_ready = state == IDLE && !rst;
    assign last     = state == BUSY && k == KW'(N - 1);
    assign res_next = {sum, result[WIDTH-1:BYTE_W]};
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            k         <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state <= BUSY;
                    a_r   <= a;
                    b_r   <= b ^ {WIDTH{sub}};
                    carry <= sub;
                    k     <= '0;
                end
                BUSY: begin
                    a_r    <= {8'b0, a_r[WIDTH-1:BYTE_W]};
                    b_r    <= {8'b0, b_r[WIDTH-1:BYTE_W]};
                    carry  <= cout;
                    result <= res_next;
                    k      <= k + 1'b1;
                    if (last) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ADD_SEQ_FLAGS_EN
    logic n_r, z_r, c_r, v_r;
    always_ff @(posedge clk) begin
        if (rst) begin
            {n_r, z_r, c_r, v_r} <= 4'b0;
        end else if (last) begin
            n_r <= sum[7];
            z_r <= res_next == '0;
            c_r <= cout;
            v_r <= a_r[7] == b_r[7] && sum[7] != a_r[7];
        end
    end
    assign {flag_n, flag_z, flag_c, flag_v} = {n_r, z_r, c_r, v_r};
`else
    assign {flag_n, flag_z, flag_c, flag_v} = 4'b0;
`endif
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: randomized self-checking bench for add_seq_ctrl against an arithmetic reference model
module tb_add_seq_ctrl;
    localparam int W = 32;
    localparam int N = W / 8;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         flag_n, flag_z, flag_c, flag_v;
    int asserts = 0;
    int fails = 0;
    add_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
    );
    always #5 clk = ~clk;
    function automatic logic [W-1:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        return s ? x - y : x + y;
    endfunction
    function automatic logic [3:0] model_flags(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W-1:0] r;
        logic [W:0]   wide;
        longint       sr;
        logic         n, z, c, v;
        r    = model_res(x, y, s);
        wide = {1'b0, x} + {1'b0, y};
        sr   = s ? longint'($signed(x)) - longint'($signed(y)) : longint'($signed(x)) + longint'($signed(y));
        n    = r[W-1];
        z    = r == '0;
        c    = s ? x >= y : wide[W];
        v    = sr > 64'sd2147483647 || sr < -64'sd2147483648;
`ifdef ADD_SEQ_FLAGS_EN
        return {n, z, c, v};
`else
        return {4'b0} & {n, z, c, v};
`endif
    endfunction
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int hold,
                          output int lat, output logic [W-1:0] r, output logic [3:0] f);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        a = x; b = y; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        f = {flag_n, flag_z, flag_c, flag_v};
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        asserts++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        asserts++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        asserts++;
        if (result !== '0 || {flag_n, flag_z, flag_c, flag_v} !== 4'b0) begin
            fails++; $display("FAIL reset_outputs got %h/%b want 0/0000", result, {flag_n, flag_z, flag_c, flag_v});
        end
        rst = 1'b0;
        #1;
        asserts++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
    endtask
    task automatic test_directed();
        logic [W-1:0] xs[4] = '{32'h0000_00FF, 32'h0000_0005, 32'h7FFF_FFFF, 32'h0000_0000};
        logic [W-1:0] ys[4] = '{32'h0000_0001, 32'h0000_0005, 32'h0000_0001, 32'h0000_0001};
        logic         ss[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] rw[4] = '{32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [3:0]   fw[4] = '{4'b0000, 4'b0110, 4'b1001, 4'b1000};
        int lat;
        logic [W-1:0] r;
        logic [3:0] f, fexp;
        for (int i = 0; i < 4; i++) begin
            run_op(xs[i], ys[i], ss[i], 0, lat, r, f);
`ifdef ADD_SEQ_FLAGS_EN
            fexp = fw[i];
`else
            fexp = 4'b0;
`endif
            asserts++;
            if (lat !== N + 1) begin fails++; $display("FAIL directed%0d_latency got %0d want %0d", i, lat, N + 1); end
            asserts++;
            if (r !== rw[i]) begin fails++; $display("FAIL directed%0d_result got %h want %h", i, r, rw[i]); end
            asserts++;
            if (f !== fexp) begin fails++; $display("FAIL directed%0d_flags got %b want %b", i, f, fexp); end
        end
    endtask
    task automatic test_random();
        logic [W-1:0] x, y, r;
        logic s;
        logic [3:0] f;
        int lat;
        for (int i = 0; i < 30; i++) begin
            x = $urandom;
            y = (i % 5 == 0) ? x : $urandom;
            s = 1'($urandom_range(0, 1));
            run_op(x, y, s, $urandom_range(0, 3), lat, r, f);
            asserts++;
            if (lat !== N + 1 || r !== model_res(x, y, s)) begin
                fails++; $display("FAIL random%0d_result got %h lat %0d want %h lat %0d", i, r, lat, model_res(x, y, s), N + 1);
            end
            asserts++;
            if (f !== model_flags(x, y, s)) begin
                fails++; $display("FAIL random%0d_flags got %b want %b", i, f, model_flags(x, y, s));
            end
        end
    endtask
    task automatic test_backpressure();
        logic [W-1:0] x, y, x2, y2, rexp;
        logic [3:0] fexp;
        int lat;
        x = $urandom; y = $urandom; x2 = $urandom; y2 = $urandom;
        rexp = model_res(x, y, 1'b1);
        fexp = model_flags(x, y, 1'b1);
        a = x; b = y; sub = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        a = x2; b = y2; sub = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        for (int i = 0; i < 3; i++) begin
            asserts++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                fails++; $display("FAIL hold%0d_handshake got valid %b ready %b want 1 0", i, out_valid, in_ready);
            end
            asserts++;
            if (result !== rexp || {flag_n, flag_z, flag_c, flag_v} !== fexp) begin
                fails++; $display("FAIL hold%0d_stable got %h/%b want %h/%b", i, result, {flag_n, flag_z, flag_c, flag_v}, rexp, fexp);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        asserts++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL hold_return_idle got ready %b valid %b want 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        asserts++;
        if (lat !== N + 1 || result !== model_res(x2, y2, 1'b0)) begin
            fails++; $display("FAIL hold_next_op got %h lat %0d want %h lat %0d", result, lat, model_res(x2, y2, 1'b0), N + 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask
    task automatic test_reset_abort();
        int seen;
        a = $urandom; b = $urandom; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        asserts++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++; $display("FAIL abort_in_reset got ready %b valid %b want 0 0", in_ready, out_valid);
        end
        asserts++;
        if (result !== '0 || {flag_n, flag_z, flag_c, flag_v} !== 4'b0) begin
            fails++; $display("FAIL abort_cleared got %h/%b want 0/0000", result, {flag_n, flag_z, flag_c, flag_v});
        end
        rst = 1'b0;
        #1;
        asserts++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b want 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        asserts++;
        if (seen !== 0) begin fails++; $display("FAIL abort_no_valid got %0d valid cycles want 0", seen); end
    endtask
    task automatic test_back_to_back();
        logic [W-1:0] x, y, x2, y2;
        int cnt, vcnt;
        x = $urandom; y = $urandom; x2 = $urandom; y2 = $urandom;
        out_ready = 1'b1;
        a = x; b = y; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = x2; b = y2; sub = 1'b1;
        cnt = 0; vcnt = 0;
        while (!in_ready && cnt < 50) begin
            if (out_valid) begin
                vcnt++;
                asserts++;
                if (result !== model_res(x, y, 1'b0)) begin
                    fails++; $display("FAIL b2b_first got %h want %h", result, model_res(x, y, 1'b0));
                end
            end
            @(posedge clk); #1;
            cnt++;
        end
        asserts++;
        if (cnt !== N + 1 || vcnt !== 1) begin
            fails++; $display("FAIL b2b_throughput got %0d cycles %0d valid want %0d cycles 1 valid", cnt, vcnt, N + 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 50) begin @(posedge clk); #1; cnt++; end
        asserts++;
        if (cnt !== N + 1 || result !== model_res(x2, y2, 1'b1) || {flag_n, flag_z, flag_c, flag_v} !== model_flags(x2, y2, 1'b1)) begin
            fails++; $display("FAIL b2b_second got %h/%b lat %0d want %h/%b lat %0d", result, {flag_n, flag_z, flag_c, flag_v}, cnt,
                              model_res(x2, y2, 1'b1), model_flags(x2, y2, 1'b1), N + 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        asserts++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL b2b_single_done got ready %b valid %b want 1 0", in_ready, out_valid);
        end
    endtask
    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
